// File: rtl/arbitro_mux_2x8.sv
// Round-robin arbiter for two burst requesters sharing a 2:1 byte mux.
// The granted requester's bytes are registered onto saida with a valid strobe.
module arbitro_mux_2x8 #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  tam0,
  input  logic [LEN_W-1:0]  tam1,
  input  logic [DATA_W-1:0] entrada1,
  input  logic [DATA_W-1:0] entrada2,
  input  logic              pronto,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              sinalMux,
  output logic [DATA_W-1:0] saida,
  output logic              saida_valido
);

  typedef enum logic {
    OCIOSO,
    OCUPADO
  } estado_t;

  estado_t           estado;
  logic [LEN_W-1:0]  contador;
  logic              ultimo;
  logic              req_dono;
  logic [DATA_W-1:0] dado;
  logic              pega0;
  logic              pega1;

  assign ack0 = gnt0 & req0 & pronto;
  assign ack1 = gnt1 & req1 & pronto;

  // while busy, sinalMux always names the owner
  assign req_dono = sinalMux ? req1 : req0;
  assign dado     = sinalMux ? entrada2 : entrada1;

  // on a tie the requester that did not go last wins
  assign pega0 = req0 & (~req1 | ultimo);
  assign pega1 = req1 & ~pega0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      sinalMux     <= 1'b0;
      saida        <= '0;
      saida_valido <= 1'b0;
      contador     <= '0;
      ultimo       <= 1'b1;
    end else begin
      saida_valido <= 1'b0;
      case (estado)
        OCIOSO: begin
          unique case (1'b1)
            pega0: begin
              gnt0     <= 1'b1;
              sinalMux <= 1'b0;
              contador <= tam0;
              estado   <= OCUPADO;
            end
            pega1: begin
              gnt1     <= 1'b1;
              sinalMux <= 1'b1;
              contador <= tam1;
              estado   <= OCUPADO;
            end
            default: ;
          endcase
        end
        OCUPADO: begin
          if (!req_dono) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            ultimo <= sinalMux;
            estado <= OCIOSO;
          end else if (pronto) begin
            saida        <= dado;
            saida_valido <= 1'b1;
            if (contador == '0) begin
              gnt0   <= 1'b0;
              gnt1   <= 1'b0;
              ultimo <= sinalMux;
              estado <= OCIOSO;
            end else begin
              contador <= contador - 1'b1;
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux_2x8.sv
// Bench for arbitro_mux_2x8: per-cycle vector table with a scoreboard
// queue, invariant monitor and an asynchronous mid-burst reset sequence.
module tb_arbitro_mux_2x8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] tam0 = '0;
  logic [3:0] tam1 = '0;
  logic [7:0] entrada1 = '0;
  logic [7:0] entrada2 = '0;
  logic       pronto = 1'b0;
  logic       gnt0, gnt1, ack0, ack1;
  logic       sinalMux, saida_valido;
  logic [7:0] saida;

  int errors = 0;
  int checks = 0;

  arbitro_mux_2x8 #(.LEN_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .tam0(tam0), .tam1(tam1),
    .entrada1(entrada1), .entrada2(entrada2),
    .pronto(pronto),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .sinalMux(sinalMux),
    .saida(saida),
    .saida_valido(saida_valido)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // c = {rs, req0, req1, pronto}
  // x = {ack0, ack1, gnt0, gnt1, sinalMux, saida_valido}
  typedef struct {
    logic [3:0] c;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [5:0] x;
    logic [7:0] sd;
  } vec_t;

  vec_t        tab[$];
  logic [11:0] sb[$];
  logic [11:0] expv;

  task automatic add(input logic [3:0] c, input logic [3:0] t0,
                     input logic [3:0] t1, input logic [7:0] e1,
                     input logic [7:0] e2, input logic [5:0] x,
                     input logic [7:0] sd);
    vec_t v;
    v.c  = c;
    v.t0 = t0;
    v.t1 = t1;
    v.e1 = e1;
    v.e2 = e2;
    v.x  = x;
    v.sd = sd;
    tab.push_back(v);
  endtask

  // invariants, sampled at the edge with pre-edge values
  logic       inv_pend;
  logic [7:0] inv_d;
  always @(posedge clock) begin
    if (!reset) begin
      chk("gnt onehot", 32'(gnt0 & gnt1), 32'd0);
      chk("ack0 w/o gnt0", 32'(ack0 & ~gnt0), 32'd0);
      chk("ack1 w/o gnt1", 32'(ack1 & ~gnt1), 32'd0);
      inv_pend = ack0 | ack1;
      inv_d    = ack1 ? entrada2 : entrada1;
      #1;
      if (!reset) begin
        chk("valid vs ack", 32'(saida_valido), 32'(inv_pend));
        if (inv_pend)
          chk("beat data", 32'(saida), 32'(inv_d));
      end
    end
  end

  initial begin
    // single beat on requester 0
    add(4'b0101, 4'd0, 4'd0, 8'h00, 8'h00, 6'b001000, 8'h00);
    add(4'b0101, 4'd0, 4'd0, 8'h00, 8'h00, 6'b100001, 8'h00);
    add(4'b0001, 4'd0, 4'd0, 8'h00, 8'h00, 6'b000000, 8'h00);
    // tie from reset, two-beat bursts alternating
    add(4'b1111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b001000, 8'h00);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b101001, 8'h00);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b100001, 8'h00);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b000110, 8'h00);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b010111, 8'hff);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b010011, 8'hff);
    add(4'b0111, 4'd1, 4'd1, 8'h00, 8'hff, 6'b001000, 8'hff);
    add(4'b0001, 4'd1, 4'd1, 8'h00, 8'hff, 6'b000000, 8'hff);
    // four beats on requester 1 with a three-cycle stall
    add(4'b0011, 4'd9, 4'd3, 8'haa, 8'hff, 6'b000110, 8'hff);
    add(4'b0011, 4'd9, 4'd3, 8'haa, 8'hff, 6'b010111, 8'hff);
    add(4'b0010, 4'd9, 4'd3, 8'haa, 8'h01, 6'b000110, 8'hff);
    add(4'b0010, 4'd2, 4'd3, 8'hbb, 8'h02, 6'b000110, 8'hff);
    add(4'b0010, 4'd5, 4'd3, 8'hcc, 8'h03, 6'b000110, 8'hff);
    add(4'b0011, 4'd9, 4'd3, 8'haa, 8'h11, 6'b010111, 8'h11);
    add(4'b0011, 4'd9, 4'd3, 8'haa, 8'h22, 6'b010111, 8'h22);
    add(4'b0011, 4'd9, 4'd3, 8'haa, 8'h33, 6'b010011, 8'h33);
    add(4'b0001, 4'd9, 4'd3, 8'haa, 8'h33, 6'b000010, 8'h33);
    // requester 0 aborts after one beat, pending requester 1 wins
    add(4'b0111, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b001000, 8'h33);
    add(4'b0111, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b101001, 8'h5a);
    add(4'b0011, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b000000, 8'h5a);
    add(4'b0111, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b000110, 8'h5a);
    add(4'b0111, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b010011, 8'hc3);
    add(4'b0001, 4'd3, 4'd0, 8'h5a, 8'hc3, 6'b000010, 8'hc3);
    // set up a requester 1 burst to be hit by reset
    add(4'b0101, 4'd0, 4'd3, 8'h77, 8'h99, 6'b001000, 8'hc3);
    add(4'b0101, 4'd0, 4'd3, 8'h77, 8'h99, 6'b100001, 8'h77);
    add(4'b0011, 4'd0, 4'd3, 8'h77, 8'h99, 6'b000110, 8'h77);
    add(4'b0011, 4'd0, 4'd3, 8'h77, 8'h99, 6'b010111, 8'h99);

    #1 reset = 1'b1;
    #2;
    chk("reset regs",
        32'({gnt0, gnt1, sinalMux, saida_valido, saida}), 32'd0);
    chk("reset acks", 32'({ack0, ack1}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clock);
      if (tab[i].c[3]) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      req0     = tab[i].c[2];
      req1     = tab[i].c[1];
      pronto   = tab[i].c[0];
      tam0     = tab[i].t0;
      tam1     = tab[i].t1;
      entrada1 = tab[i].e1;
      entrada2 = tab[i].e2;
      sb.push_back({tab[i].x[3:0], tab[i].sd});
      #1;
      chk($sformatf("row%0d acks", i),
          32'({ack0, ack1}), 32'(tab[i].x[5:4]));
      @(posedge clock);
      #1;
      expv = sb.pop_front();
      chk($sformatf("row%0d regs", i),
          32'({gnt0, gnt1, sinalMux, saida_valido, saida}), 32'(expv));
    end

    // asynchronous reset between edges, mid-burst
    #2 reset = 1'b1;
    #1;
    chk("async reset regs",
        32'({gnt0, gnt1, sinalMux, saida_valido, saida}), 32'd0);
    chk("async reset acks", 32'({ack0, ack1}), 32'd0);

    @(negedge clock);
    reset    = 1'b0;
    req0     = 1'b1;
    req1     = 1'b1;
    tam0     = 4'd0;
    tam1     = 4'd0;
    entrada1 = 8'h42;
    entrada2 = 8'h24;
    pronto   = 1'b1;
    sb.push_back({4'b1000, 8'h00});
    @(posedge clock);
    #1;
    expv = sb.pop_front();
    chk("tie after reset",
        32'({gnt0, gnt1, sinalMux, saida_valido, saida}), 32'(expv));
    @(negedge clock);
    sb.push_back({4'b0001, 8'h42});
    #1;
    chk("ack after reset", 32'({ack0, ack1}), 32'd2);
    @(posedge clock);
    #1;
    expv = sb.pop_front();
    chk("beat after reset",
        32'({gnt0, gnt1, sinalMux, saida_valido, saida}), 32'(expv));

    @(negedge clock);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
